// File: rtl/fys_perm.sv
// Fisher-Yates permutation generator: identity load, in-place xorshift64 shuffle with masked
// rejection sampling, then registered read port. Define FYS_PERM_STATS_EN to add rej_cnt.
module fys_perm #(
    parameter int N = 8192,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [63:0]  seed,
    output logic         busy,
    output logic         done,
    input  logic         rd_en,
    input  logic [W-1:0] rd_addr,
    output logic [W-1:0] rd_data
`ifdef FYS_PERM_STATS_EN
    ,
    output logic [31:0]  rej_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, DRAW, SWAP_RD, SWAP_WR, FIN} state_t;

    state_t       state;
    logic [63:0]  x, x1, x2, x_next;
    logic [W-1:0] c, i, r, mask, cand, q_a, q_b;
    logic         accept, rej, swap_we;
    logic [W-1:0] mem [N];

    assign x1     = x ^ (x << 13);
    assign x2     = x1 ^ (x1 >> 7);
    assign x_next = x2 ^ (x2 << 17);

    // Smear i's top set bit downward: smallest 2^k-1 covering i
    always_comb begin
        mask = i;
        for (int k = 1; k < W; k++) mask = mask | (i >> k);
    end

    assign cand    = x_next[W-1:0] & mask;
    assign accept  = start && (state == IDLE || state == FIN);
    assign rej     = (state == DRAW) && (cand > i);
    assign swap_we = (state == SWAP_WR) && (r != i);

    // Storage: port A addresses c/i, port B addresses r; no reset on contents
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[c] <= c;
        end else if (swap_we) begin
            mem[i] <= q_b;
            mem[r] <= q_a;
        end
        if (state == SWAP_RD) begin
            q_a <= mem[i];
            q_b <= mem[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            x     <= 64'h1;
            c     <= '0;
            i     <= '0;
            r     <= '0;
        end else if (accept) begin
            x     <= (seed == 64'h0) ? 64'h1 : seed;
            c     <= '0;
            state <= INIT;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    c <= c + W'(1);
                    if (c == W'(N - 1)) begin
                        if (N == 1) begin
                            state <= FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            i     <= W'(N - 1);
                            state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    x <= x_next;
                    if (!rej) begin
                        r     <= cand;
                        state <= SWAP_RD;
                    end
                end
                SWAP_RD: state <= SWAP_WR;
                SWAP_WR: begin
                    i <= i - W'(1);
                    if (i == W'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= DRAW;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if (done && rd_en)
            rd_data <= (32'(rd_addr) >= 32'(N)) ? '0 : mem[rd_addr];
    end

`ifdef FYS_PERM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rej_cnt <= '0;
        else if (accept)
            rej_cnt <= '0;
        else if (rej && rej_cnt != '1)
            rej_cnt <= rej_cnt + 32'd1;
    end
`endif

endmodule
